// File: rtl/bfly_input_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bfly_input_scheduler
// Description : Collects one frame of N complex samples, then issues the N/2
//               radix-2 butterfly operand pairs (x = buf[k], y = buf[k+N/2])
//               with twiddle index k and a last-pair marker, under a
//               valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module bfly_input_scheduler #(
    parameter int NBD   = 8,
    parameter int LOG2N = 3
) (
    input  logic                                   clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic [NBD-1:0]                         i_real,
    input  logic [NBD-1:0]                         i_imag,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic [NBD-1:0]                         o_x_real,
    output logic [NBD-1:0]                         o_x_imag,
    output logic [NBD-1:0]                         o_y_real,
    output logic [NBD-1:0]                         o_y_imag,
    output logic [((LOG2N > 1) ? LOG2N-1 : 1)-1:0] o_tw_idx,
    output logic                                   o_last
);

    localparam int               c_N       = 1 << LOG2N;
    localparam int               c_TW_W    = (LOG2N > 1) ? LOG2N-1 : 1;
    localparam logic [LOG2N-1:0] c_HALF    = LOG2N'(c_N / 2);
    localparam logic [LOG2N-1:0] c_LAST_RD = LOG2N'(c_N / 2 - 1);
    localparam logic [LOG2N-1:0] c_LAST_WR = LOG2N'(c_N - 1);

    localparam logic [0:0] c_FILL  = 1'b0;
    localparam logic [0:0] c_DRAIN = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [LOG2N-1:0] r_wr_cnt;
    logic [LOG2N-1:0] r_rd_cnt;
    logic [LOG2N-1:0] w_y_addr;
    logic             w_wr_en;
    logic             w_load;
    logic             w_out_done;

    // Sample store: {real, imag} per entry; contents never need clearing
    // because a frame is only drained after all N entries are rewritten.
    logic [2*NBD-1:0] r_buf [0:c_N-1];

    logic              r_out_valid;
    logic [NBD-1:0]    r_x_real;
    logic [NBD-1:0]    r_x_imag;
    logic [NBD-1:0]    r_y_real;
    logic [NBD-1:0]    r_y_imag;
    logic [c_TW_W-1:0] r_tw_idx;
    logic              r_out_last;

    assign w_y_addr = r_rd_cnt + c_HALF;

    // Next-state and handshake decode; the output register is refilled when
    // empty or consumed, except once the final pair is already sitting in it.
    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        w_wr_en      = 1'b0;
        w_load       = 1'b0;
        w_out_done   = 1'b0;
        case (r_state)
            c_FILL: begin
                o_ready = 1'b1;
                w_wr_en = i_valid;
                if (i_valid && (r_wr_cnt == c_LAST_WR)) begin
                    w_state_next = c_DRAIN;
                end
            end
            c_DRAIN: begin
                w_load     = !r_out_valid || (i_ready && !r_out_last);
                w_out_done = r_out_valid && i_ready && r_out_last;
                if (w_out_done) begin
                    w_state_next = c_FILL;
                end
            end
            default: begin
                w_state_next = c_FILL;
            end
        endcase
    end

    // Sample buffer write port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_cnt] <= {i_real, i_imag};
        end
    end

    // State, counters and output pair register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= c_FILL;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_x_real    <= '0;
            r_x_imag    <= '0;
            r_y_real    <= '0;
            r_y_imag    <= '0;
            r_tw_idx    <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                {r_x_real, r_x_imag} <= r_buf[r_rd_cnt];
                {r_y_real, r_y_imag} <= r_buf[w_y_addr];
                r_tw_idx    <= r_rd_cnt[c_TW_W-1:0];
                r_out_last  <= (r_rd_cnt == c_LAST_RD);
                r_rd_cnt    <= r_rd_cnt + 1'b1;
            end else if (w_out_done) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_rd_cnt    <= '0;
            end
        end
    end

    assign o_valid  = r_out_valid;
    assign o_x_real = r_x_real;
    assign o_x_imag = r_x_imag;
    assign o_y_real = r_y_real;
    assign o_y_imag = r_y_imag;
    assign o_tw_idx = r_tw_idx;
    assign o_last   = r_out_last;

endmodule
`default_nettype wire

// File: doc/bfly_input_scheduler.md
BFLY_INPUT_SCHEDULER -- requirements
Module: bfly_input_scheduler

Interface
REQ-001 SHALL have parameter NBD, default 8: data width in bits, two's complement, per real/imag component.
REQ-002 SHALL have parameter LOG2N, default 3: log2 of frame length N; N = 2**LOG2N; LOG2N >= 1.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port i_valid  input  1: upstream sample valid.
REQ-006 SHALL have port o_ready  output  1: block accepts a sample this cycle.
REQ-007 SHALL have port i_real  input  NBD: upstream sample, real part.
REQ-008 SHALL have port i_imag  input  NBD: upstream sample, imaginary part.
REQ-009 SHALL have port o_valid  output  1: butterfly operand pair valid.
REQ-010 SHALL have port i_ready  input  1: downstream butterfly stage accepts the pair.
REQ-011 SHALL have ports o_x_real, o_x_imag, o_y_real, o_y_imag  output  NBD each: butterfly operands x and y.
REQ-012 SHALL have port o_tw_idx  output  LOG2N-1 (min 1): twiddle index k for the pair.
REQ-013 SHALL have port o_last  output  1: marks final pair of the frame.

Function
REQ-014 SHALL implement a two-state FSM, FILL and DRAIN; reset state FILL.
REQ-015 In FILL, SHALL drive o_ready=1; in DRAIN, o_ready=0.
REQ-016 In FILL, SHALL store {i_real,i_imag} at buffer address wr_cnt on each i_valid&&o_ready cycle, then increment wr_cnt.
REQ-017 SHALL go FILL->DRAIN on the edge that accepts sample N-1; wr_cnt wraps to 0 on the same edge.
REQ-018 In DRAIN, SHALL load the output register with pair rd_cnt whenever o_valid==0 or i_ready==1: x=buf[rd_cnt], y=buf[rd_cnt+N/2], o_tw_idx=rd_cnt, o_last=(rd_cnt==N/2-1); then increment rd_cnt.
REQ-019 SHALL assert the first o_valid of a frame exactly 2 cycles after the cycle of the last input handshake.
REQ-020 SHALL hold o_valid and all output data/index/last bits stable while o_valid==1 and i_ready==0.
REQ-021 With i_ready held 1, SHALL issue one pair per cycle: N/2 consecutive o_valid cycles.
REQ-022 SHALL go DRAIN->FILL on the edge where o_valid&&i_ready&&o_last; o_valid deasserts on that edge, rd_cnt resets to 0, and o_ready is 1 in the following cycle.
REQ-023 SHALL ignore i_valid, i_real and i_imag while in DRAIN: no buffer write and no counter change.
REQ-024 SHALL pass data bit-exact, with no arithmetic, sign extension or rounding.
REQ-025 SHALL not stall on i_valid gaps in FILL: wr_cnt holds, and partial frames persist until completed.

Reset
REQ-026 On i_rst_n low, SHALL immediately force state=FILL, wr_cnt=0, rd_cnt=0, o_valid=0, o_last=0, o_tw_idx=0, and o_x_*/o_y_*=0.
REQ-027 Buffer contents SHALL need no reset; a reset mid-FILL or mid-DRAIN SHALL discard the partial frame, and no stale pair SHALL be emitted afterwards.
REQ-028 SHALL give o_ready=1 in the first cycle after i_rst_n is released.

Verification
REQ-029 Defaults, i_ready=1: feed 8 samples back-to-back, real=k+1, imag=-(k+1) for k=0..7 -> 2 cycles later 4 consecutive pairs: x.re=1,2,3,4; y.re=5,6,7,8; x.im=-1..-4; y.im=-5..-8; o_tw_idx=0,1,2,3; o_last only on the 4th.
REQ-030 Backpressure: same frame, i_ready=0 for 3 cycles when pair 1 is presented -> pair 1 (x.re=2, y.re=6, idx=1) held stable for 4 cycles; no pair lost or duplicated.
REQ-031 Input gaps: i_valid toggling 1,0,1,0 -> exactly 8 accepted samples produce the same 4 pairs as REQ-029; o_ready stays 1 throughout FILL.
REQ-032 DRAIN lockout: i_valid=1 with real=0x7F during DRAIN -> o_ready=0, the output pairs are unaffected, and the next frame starts with its own first sample at address 0.
REQ-033 Reset mid-operation: assert i_rst_n=0 after 5 samples, release it, then feed a full 8-sample frame with real=0x80..0x87 -> pairs (0x80,0x84),(0x81,0x85),(0x82,0x86),(0x83,0x87); o_valid stays 0 during reset.
REQ-034 Back-to-back frames: two frames with continuous i_valid and i_ready -> o_ready returns 1 the cycle after the o_last handshake; the second frame's pairs are correct; LOG2N=1 run gives a single pair with o_tw_idx=0 and o_last=1.
